// File: rtl/out_pcm_sched_pkg.sv
// rtl/out_pcm_sched_pkg.sv - shared types and constants for the OUT_PCM frame scheduler
package out_pcm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RATE_40 = 2'b00,
    RATE_32 = 2'b01,
    RATE_24 = 2'b10,
    RATE_16 = 2'b11
  } rate_t;

  localparam logic [7:0] ULAW_IDLE = 8'hFF;
  localparam logic [7:0] ALAW_IDLE = 8'hD5;

  function automatic logic [7:0] idle_code(input logic law);
    return law ? ALAW_IDLE : ULAW_IDLE;
  endfunction

endpackage

// File: rtl/out_pcm_sched_if.sv
// rtl/out_pcm_sched_if.sv - operand handshake and OUT_PCM drive/result bus
interface out_pcm_sched_if #(parameter int CH_W = 5);

  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [15:0]     in_sr;
  logic [14:0]     in_se;
  logic [4:0]      in_i;
  logic [12:0]     in_y;
  logic [1:0]      in_rate;
  logic            in_law;

  logic [15:0]     op_sr;
  logic [14:0]     op_se;
  logic [4:0]      op_i;
  logic [12:0]     op_y;
  logic [1:0]      op_rate;
  logic            op_law;
  logic [7:0]      op_sd;

  modport master (
    output in_valid, in_ch, in_sr, in_se, in_i, in_y, in_rate, in_law, op_sd,
    input  in_ready, op_sr, op_se, op_i, op_y, op_rate, op_law
  );

  modport slave (
    input  in_valid, in_ch, in_sr, in_se, in_i, in_y, in_rate, in_law, op_sd,
    output in_ready, op_sr, op_se, op_i, op_y, op_rate, op_law
  );

endinterface

// File: rtl/out_pcm_sched_pcm_bank_ram.sv
// rtl/out_pcm_sched_pcm_bank_ram.sv - double-banked per-channel PCM store with valid masks
module pcm_bank_ram
  import out_pcm_sched_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic            wr_bank,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [7:0]      wr_data,
  output logic            wr_hit,
  input  logic            clr_en,
  input  logic            clr_bank,
  input  logic            rd_bank,
  input  logic [CH_W-1:0] rd_ch,
  input  logic            idle_law,
  output logic [7:0]      rd_data
);

  logic [7:0]        mem  [2][NUM_CH];
  logic [NUM_CH-1:0] mask [2];
  logic              rd_ok;

  assign wr_hit = mask[wr_bank][wr_ch];
  assign rd_ok  = 32'(rd_ch) < NUM_CH;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_ch] <= wr_data;
  end

  // Clear and write never target the same bank: the clear always hits the bank being opened.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask[0] <= '0;
      mask[1] <= '0;
      rd_data <= 8'h00;
    end else begin
      if (clr_en) mask[clr_bank] <= '0;
      if (wr_en)  mask[wr_bank][wr_ch] <= 1'b1;
      rd_data <= (rd_ok && mask[rd_bank][rd_ch]) ? mem[rd_bank][rd_ch] : idle_code(idle_law);
    end
  end

endmodule

// File: rtl/out_pcm_sched.sv
// rtl/out_pcm_sched.sv - schedules per-channel operands through one OUT_PCM, banks SD per frame
// Optional OUT_PCM_SCHED_STATS_EN adds frame and overrun counters.
module out_pcm_sched
  import out_pcm_sched_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fs,
  out_pcm_sched_if.slave  bus,
  input  logic            idle_law,
  input  logic [CH_W-1:0] rd_ch,
  output logic [7:0]      rd_sd,
  output logic            frame_done,
  output logic            overrun,
  output logic            ch_err,
  input  logic            err_clr
`ifdef OUT_PCM_SCHED_STATS_EN
  ,
  output logic [15:0]     stat_frames,
  output logic [7:0]      stat_ovr
`endif
);

  localparam int CNT_W = $clog2(NUM_CH + 1);

  state_t            state, state_nxt;
  logic              in_ready;
  logic [CH_W-1:0]   ch_q;
  logic              wr_bank;
  logic [CNT_W-1:0]  done_cnt;
  logic              hs, swap, ovr_evt, capture, ch_ok, wr_hit, new_ch, ch_evt;

  assign bus.in_ready = in_ready;
  assign hs      = bus.in_valid && in_ready;
  assign swap    = fs && (state != ST_IDLE);
  assign ovr_evt = fs && ((state == ST_RUN) || (state == ST_EVAL));
  assign capture = (state == ST_EVAL);
  assign ch_ok   = 32'(ch_q) < NUM_CH;
  assign new_ch  = capture && ch_ok && !wr_hit;
  assign ch_evt  = capture && (!ch_ok || wr_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE: if (fs) state_nxt = ST_RUN;
      ST_RUN: begin
        in_ready = 1'b1;
        if (hs) state_nxt = ST_EVAL;
      end
      ST_EVAL: state_nxt = (new_ch && (done_cnt + CNT_W'(1) == CNT_W'(NUM_CH))) ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    // A set accepted on the swap edge belongs to the new frame.
    if (swap) state_nxt = hs ? ST_EVAL : ST_RUN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.op_sr   <= '0;
      bus.op_se   <= '0;
      bus.op_i    <= '0;
      bus.op_y    <= '0;
      bus.op_rate <= '0;
      bus.op_law  <= 1'b0;
      ch_q        <= '0;
      wr_bank     <= 1'b0;
      done_cnt    <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      ch_err      <= 1'b0;
    end else begin
      if (hs) begin
        bus.op_sr   <= bus.in_sr;
        bus.op_se   <= bus.in_se;
        bus.op_i    <= bus.in_i;
        bus.op_y    <= bus.in_y;
        bus.op_rate <= bus.in_rate;
        bus.op_law  <= bus.in_law;
        ch_q        <= bus.in_ch;
      end
      if (swap) begin
        wr_bank  <= ~wr_bank;
        done_cnt <= '0;
      end else if (new_ch) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
      frame_done <= capture && (state_nxt == ST_DONE);
      if (ovr_evt)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (ch_evt)       ch_err  <= 1'b1;
      else if (err_clr) ch_err  <= 1'b0;
    end
  end

`ifdef OUT_PCM_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_frames <= '0;
      stat_ovr    <= '0;
    end else begin
      if (swap) stat_frames <= stat_frames + 16'd1;
      if (ovr_evt && (stat_ovr != 8'hFF)) stat_ovr <= stat_ovr + 8'd1;
    end
  end
`endif

  pcm_bank_ram #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_ram (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (capture && ch_ok),
    .wr_bank  (wr_bank),
    .wr_ch    (ch_q),
    .wr_data  (bus.op_sd),
    .wr_hit   (wr_hit),
    .clr_en   (fs),
    .clr_bank ((state == ST_IDLE) ? wr_bank : ~wr_bank),
    .rd_bank  (~wr_bank),
    .rd_ch    (rd_ch),
    .idle_law (idle_law),
    .rd_data  (rd_sd)
  );

endmodule

// File: doc/out_pcm_sched.md
# out_pcm_sched

Frame scheduler for the shared OUT_PCM datapath in the multi-channel ADPCM decoder (mcac_bs). Per-channel decoder results (SR, SE, I, Y, RATE, LAW) arrive over a valid/ready interface. The block drives them one at a time through a single combinational OUT_PCM instance and captures each SD byte into a double-buffered per-channel PCM store. Banks swap on frame sync, so the downstream serializer always reads the complete previous frame.

## Interface
- NUM_CH, 32, number of channels per frame (≤ 2^CH_W)
- CH_W, 5, channel index width
- CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- FS  in  1  frame sync, one-cycle pulse per 125 µs frame
- IN_VALID  in  1  operand set valid
- IN_READY  out  1  scheduler accepts operand set
- IN_CH  in  CH_W  channel index
- IN_SR / IN_SE / IN_I / IN_Y  in  16/15/5/13  OUT_PCM operands
- IN_RATE  in  2  00=40, 01=32, 10=24, 11=16 kb/s
- IN_LAW  in  1  0=µ-law, 1=A-law
- OP_SR / OP_SE / OP_I / OP_Y / OP_RATE / OP_LAW  out  16/15/5/13/2/1  registered drive to OUT_PCM
- OP_SD  in  8  OUT_PCM result
- IDLE_LAW  in  1  law used for idle fill on unwritten channels
- RD_CH  in  CH_W  read address, previous-frame bank
- RD_SD  out  8  PCM byte, registered
- FRAME_DONE  out  1  one-cycle pulse when NUM_CH distinct channels are written
- OVERRUN  out  1  sticky; FS arrived before FRAME_DONE
- CH_ERR  out  1  sticky; duplicate channel in a frame, or IN_CH ≥ NUM_CH
- ERR_CLR  in  1  clears OVERRUN and CH_ERR

## Operation
- States: IDLE → RUN → EVAL → RUN … → DONE → (FS) RUN.
- IDLE: entered at reset. IN_READY=0. First FS clears the write mask and enters RUN. OVERRUN is not set on this FS.
- RUN: IN_READY=1. On handshake (IN_VALID&IN_READY), operands load into the OP_* registers, IN_CH is latched, and the state moves to EVAL.
- EVAL: IN_READY=0. At the end of the cycle, OP_SD is written to bank[wr_bank][ch], the mask bit is set, and done_cnt increments if the bit was previously clear. Then go to DONE if done_cnt reaches NUM_CH, else RUN.
- Duplicate channel: the byte is overwritten, done_cnt is unchanged, and CH_ERR is set.
- IN_CH ≥ NUM_CH: accepted, not written, CH_ERR is set.
- DONE: IN_READY=0. FRAME_DONE pulses on the cycle of entry.
- FS in RUN, EVAL or DONE:
  - wr_bank toggles, the new write mask clears, done_cnt is set to 0, and the state goes to RUN.
  - An EVAL capture on the same edge still lands in the old bank.
  - FS in RUN or EVAL sets OVERRUN.
- Read side: RD_SD = bank[~wr_bank][RD_CH] if the mask bit is set; otherwise idle code 0xFF (µ-law) or 0xD5 (A-law) per IDLE_LAW.
- ERR_CLR concurrent with a new error: the error wins.

## Timing
- Reset values: IN_READY=0, all OP_*=0, RD_SD=0, FRAME_DONE=0, OVERRUN=0, CH_ERR=0, wr_bank=0, both masks clear, state IDLE.
- Throughput: one operand set per 2 cycles. NUM_CH=32 needs 64 cycles per frame.
- OP_* are valid 1 cycle after the handshake. OP_SD is sampled at the end of that cycle, so OUT_PCM gets one full cycle of combinational delay.
- RD_SD has 1-cycle latency from RD_CH. It reflects the bank swap from the cycle after the FS edge.
- FRAME_DONE asserts 1 cycle after the EVAL capture of the final channel.

## Configuration
- OUT_PCM_SCHED_STATS_EN defined:
  - Adds output STAT_FRAMES (16-bit, wraps), incremented on every FS after IDLE.
  - Adds output STAT_OVR (8-bit, saturating at 0xFF), incremented whenever OVERRUN would set.
  - Both counters reset to 0.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Package out_pcm_sched_pkg holds:
  - state enum (IDLE, RUN, EVAL, DONE)
  - rate encodings
  - idle codes ULAW_IDLE=8'hFF, ALAW_IDLE=8'hD5
- Sub-module pcm_bank_ram: 2×NUM_CH×8 storage plus per-bank valid masks, one write port, one registered read port, bank select inputs.
- The top holds the FSM, OP registers, counters and flags. OUT_PCM is instantiated outside, at the decoder level.

## Test plan
- Reset mid-EVAL (RESET_N low 3 cycles) → all outputs return to reset values. Next FS required before IN_READY=1, and no OVERRUN on that FS.
- FS, then 32 handshakes ch 0..31 with OUT_PCM stub OP_SD=ch+8'h40 → FRAME_DONE once, 64 cycles after the first handshake. After the next FS, RD_CH=5 returns 8'h45 one cycle later.
- FS, then only ch 3 written (OP_SD=8'h12), IDLE_LAW=1, then FS → OVERRUN=1. RD_CH=3 returns 0x12; RD_CH=4 returns 0xD5. With IDLE_LAW=0, RD_CH=4 returns 0xFF.
- Ch 7 sent twice in one frame (0x11 then 0x22) → CH_ERR=1, done_cnt not incremented. Read after swap returns 0x22. ERR_CLR pulse clears CH_ERR.
- FS asserted on the EVAL cycle of ch 9 (OP_SD=0x5A) → 0x5A readable at RD_CH=9 after the swap, OVERRUN=1, state RUN.
- With OUT_PCM_SCHED_STATS_EN: 3 FS pulses, 2 of them overrunning → STAT_FRAMES=3, STAT_OVR=2.
